// File: rtl/retire_pkg.sv
// retire_pkg: shared types, widths and helpers for the retire stage
package retire_pkg;
    localparam int RET_PR_W = 6;
    localparam int RET_XLEN = 32;
    typedef struct packed {
        logic                completed;
        logic                is_store;
        logic                precise_state_need;
        logic                halt;
        logic [4:0]          arch_reg;
        logic [RET_PR_W-1:0] tnew;
        logic [RET_PR_W-1:0] told;
        logic [RET_XLEN-1:0] target_pc;
    } rob_ret_t;
    typedef enum logic [1:0] {RUN, RECOVER, HALTED} retire_state_e;
    function automatic logic [5:0] popcount(input logic [31:0] v);
        popcount = '0;
        for (int i = 0; i < 32; i++) popcount = popcount + 6'(v[i]);
    endfunction
endpackage

// File: rtl/retire_select.sv
// retire_select: oldest-first contiguous retire prefix and arch-writer lanes
module retire_select
    import retire_pkg::*;
#(
    parameter int RETIRE_W = 3
) (
    input  logic                    run,
    input  logic [RETIRE_W-1:0]     head_valid,
    input  rob_ret_t [RETIRE_W-1:0] head_entry,
    input  logic [RETIRE_W-1:0]     sq_stall,
    output logic [RETIRE_W-1:0]     retire_en,
    output logic [RETIRE_W-1:0]     writer
);
    logic go;
    // walk lanes oldest-first; a blocked lane or a barrier closes the prefix
    always_comb begin
        go = run;
        retire_en = '0;
        writer = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            retire_en[i] = go && head_valid[i] && head_entry[i].completed &&
                           !(head_entry[i].is_store && sq_stall[i]);
            writer[i] = retire_en[i] && (head_entry[i].arch_reg != 5'd0);
            go = retire_en[i] && !head_entry[i].precise_state_need && !head_entry[i].halt;
        end
    end
endmodule

// File: rtl/retire_unit_n.sv
// retire_unit_n: N-wide in-order retire with branch recovery and sticky halt
// Optional feature: define RETIRE_PERF_EN to add perf_retired/perf_recover counters.
module retire_unit_n
    import retire_pkg::*;
#(
    parameter int RETIRE_W = 3,
    parameter int PR_W     = RET_PR_W,
    parameter int ROB_W    = 5,
    parameter int XLEN     = RET_XLEN
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [RETIRE_W-1:0]                 head_valid,
    input  rob_ret_t [RETIRE_W-1:0]             head_entry,
    input  logic [RETIRE_W-1:0]                 sq_stall,
    input  logic [ROB_W-1:0]                    fl_distance,
    input  logic [ROB_W-1:0]                    freelist_head,
    input  logic [31:0][PR_W-1:0]               archi_maptable,
    output logic [RETIRE_W-1:0]                 arch_wr_en,
    output logic [RETIRE_W-1:0][4:0]            arch_wr_ar,
    output logic [RETIRE_W-1:0][PR_W-1:0]       arch_wr_pr,
    output logic [RETIRE_W-1:0][PR_W-1:0]       told_out,
    output logic [RETIRE_W-1:0]                 sq_retire_en,
    output logic [RETIRE_W-1:0]                 retire_en,
    output logic [$clog2(RETIRE_W+1)-1:0]       inst_count,
    output logic                                recover_en,
    output logic [XLEN-1:0]                     recover_pc,
    output logic [31:0][PR_W-1:0]               recover_maptable,
    output logic [ROB_W-1:0]                    recover_fl_head,
    output logic                                halt
`ifdef RETIRE_PERF_EN
    ,output logic [63:0]                        perf_retired,
    output logic [63:0]                         perf_recover
`endif
);
    localparam int CNT_W = $clog2(RETIRE_W+1);
    retire_state_e state, state_n;
    logic [RETIRE_W-1:0] writer, halt_v, psn_v;
    logic [31:0][PR_W-1:0] map_n;
    logic [XLEN-1:0] pc_n;
    logic [ROB_W-1:0] fl_n;
    logic run, halt_hit, mis;

    // reset also gates retirement so every output reads 0 while held
    assign run = (state == RUN) && !reset;

    retire_select #(.RETIRE_W(RETIRE_W)) u_sel (
        .run       (run),
        .head_valid(head_valid),
        .head_entry(head_entry),
        .sq_stall  (sq_stall),
        .retire_en (retire_en),
        .writer    (writer)
    );

    assign arch_wr_en = writer;
    assign inst_count = CNT_W'(popcount(32'(retire_en)));
    assign halt_hit   = |(retire_en & halt_v);
    assign mis        = |(retire_en & psn_v) && !halt_hit;
    assign fl_n       = freelist_head - (fl_distance - ROB_W'(popcount(32'(writer))));
    assign recover_en = (state == RECOVER);
    assign halt       = (state == HALTED);

    // per-lane outputs, barrier flags and the post-retire map (higher lane wins)
    always_comb begin
        map_n = archi_maptable;
        pc_n = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            halt_v[i] = head_entry[i].halt;
            psn_v[i] = head_entry[i].precise_state_need;
            sq_retire_en[i] = retire_en[i] && head_entry[i].is_store;
            arch_wr_ar[i] = writer[i] ? head_entry[i].arch_reg : 5'd0;
            arch_wr_pr[i] = writer[i] ? head_entry[i].tnew : '0;
            told_out[i] = writer[i] ? head_entry[i].told : '0;
            if (writer[i]) map_n[head_entry[i].arch_reg] = head_entry[i].tnew;
            if (retire_en[i] && psn_v[i]) pc_n = head_entry[i].target_pc;
        end
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_n;
    end

    // next state: halt beats mispredict; RECOVER lasts one cycle; HALTED is terminal
    always_comb begin
        state_n = state;
        state_n = (state == RUN) ? (halt_hit ? HALTED : mis ? RECOVER : RUN) :
                  (state == RECOVER) ? RUN : HALTED;
    end

    // recovery record captured on a mispredict and held until the next one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            recover_pc <= '0;
            recover_maptable <= '0;
            recover_fl_head <= '0;
        end else if (mis) begin
            recover_pc <= pc_n;
            recover_maptable <= map_n;
            recover_fl_head <= fl_n;
        end
    end

`ifdef RETIRE_PERF_EN
    // free-running wrap-around performance counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_retired <= '0;
            perf_recover <= '0;
        end else begin
            perf_retired <= perf_retired + 64'(inst_count);
            perf_recover <= perf_recover + 64'(recover_en);
        end
    end
`endif
endmodule
